zz_rle_encoder: RTL and testbench

//  Run-length encoder placed directly downstream of the zig-zag reorder stage.

---
 rtl/zz_rle_encoder.sv | 251 +++++++++++++++++++++++++
 tb/tb_zz_rle_encoder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/zz_rle_encoder.sv
// Run-length encoder for zig-zag ordered 8x8 blocks: JPEG (run,size,amp) symbols incl. ZRL/EOB.
// Optional feature: define RLE_DC_DIFF_EN to emit DC as difference from the previous block's DC.
module zz_rle_encoder #(
  parameter int BW = 8
) (
  input  logic            i_clk,
  input  logic            i_Reset,
  input  logic [8*BW-1:0] i_data,
  input  logic            i_valid,
  output logic            o_ready,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [3:0]      o_run,
  output logic [3:0]      o_size,
  output logic [BW:0]     o_amp,
  output logic            o_dc,
  output logic            o_eob
);

  // state    | meaning
  // S_IDLE   | row buffer free, waiting for next row
  // S_SCAN   | walking lanes 7..0, one coefficient per cycle
  // S_ZRL    | emitting (15,0) while zero run >= 16
  // S_SYM    | emitting the nonzero AC symbol at the current lane
  // S_EOB    | emitting end-of-block after trailing zeros
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SCAN = 3'd1;
  localparam logic [2:0] S_ZRL  = 3'd2;
  localparam logic [2:0] S_SYM  = 3'd3;
  localparam logic [2:0] S_EOB  = 3'd4;

  logic [2:0]      r_state;
  logic [2:0]      r_row;
  logic [2:0]      r_lane;
  logic [5:0]      r_zrun;
  logic [8*BW-1:0] r_buf;

  logic            r_valid;
  logic [3:0]      r_run;
  logic [3:0]      r_size;
  logic [BW:0]     r_amp;
  logic            r_dc;
  logic            r_eob;

  logic [2:0]        w_nxt_state;
  logic [2:0]        w_nxt_row;
  logic [2:0]        w_nxt_lane;
  logic [5:0]        w_nxt_zrun;
  logic [5:0]        w_zrun_adv;
  logic              w_advance;
  logic              w_load;
  logic [3:0]        w_ld_run;
  logic [3:0]        w_ld_size;
  logic [BW:0]       w_ld_amp;
  logic              w_ld_dc;
  logic              w_ld_eob;
  logic              w_accept;
  logic              w_out_free;
  logic              w_is_dc;
  logic [BW-1:0]     w_coef;
  logic signed [BW:0] w_coef_ext;
  logic signed [BW:0] w_dc_val;
  logic signed [BW:0] w_sym_val;
  logic [3:0]        w_sym_size;
  logic [BW:0]       w_sym_amp;

  function automatic logic [3:0] f_size(input logic signed [BW:0] v);
    logic [BW:0] mag;
    f_size = 4'd0;
    mag = v[BW] ? ($unsigned(~v) + {{BW{1'b0}}, 1'b1}) : $unsigned(v);
    for (int i = 0; i <= BW; i++) begin
      if (mag[i]) f_size = 4'(i + 1);
    end
  endfunction

  // Negative values use one's complement form: (v-1) truncated to size bits.
  function automatic logic [BW:0] f_amp(input logic signed [BW:0] v, input logic [3:0] sz);
    logic [BW:0] mask;
    logic [BW:0] vm1;
    mask = '0;
    for (int i = 0; i <= BW; i++) begin
      if (i < int'(sz)) mask[i] = 1'b1;
    end
    vm1 = $unsigned(v) - {{BW{1'b0}}, 1'b1};
    f_amp = v[BW] ? (vm1 & mask) : $unsigned(v);
  endfunction

  assign w_accept   = (r_state == S_IDLE) && i_valid;
  assign w_out_free = !r_valid || i_ready;
  assign w_is_dc    = (r_row == 3'd0) && (r_lane == 3'd7);
  assign w_coef     = r_buf[r_lane*BW +: BW];
  assign w_coef_ext = {w_coef[BW-1], w_coef};

`ifdef RLE_DC_DIFF_EN
  logic [BW-1:0] r_prev_dc;
  logic [BW-1:0] r_dc_pend;

  assign w_dc_val = w_coef_ext - $signed({r_prev_dc[BW-1], r_prev_dc});

  // Reference advances only once the DC symbol actually leaves the block.
  always_ff @(posedge i_clk or negedge i_Reset) begin
    if (!i_Reset) begin
      r_prev_dc <= '0;
      r_dc_pend <= '0;
    end else begin
      if (w_load && w_ld_dc) r_dc_pend <= w_coef;
      if (r_valid && i_ready && r_dc) r_prev_dc <= r_dc_pend;
    end
  end
`else
  assign w_dc_val = w_coef_ext;
`endif

  assign w_sym_val  = w_is_dc ? w_dc_val : w_coef_ext;
  assign w_sym_size = f_size(w_sym_val);
  assign w_sym_amp  = f_amp(w_sym_val, w_sym_size);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_row   = r_row;
    w_nxt_lane  = r_lane;
    w_nxt_zrun  = r_zrun;
    w_zrun_adv  = r_zrun;
    w_advance   = 1'b0;
    w_load      = 1'b0;
    w_ld_run    = 4'd0;
    w_ld_size   = 4'd0;
    w_ld_amp    = '0;
    w_ld_dc     = 1'b0;
    w_ld_eob    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_valid) begin
          w_nxt_lane  = 3'd7;
          w_nxt_state = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_is_dc) begin
          if (w_out_free) begin
            w_load     = 1'b1;
            w_ld_size  = w_sym_size;
            w_ld_amp   = w_sym_amp;
            w_ld_dc    = 1'b1;
            w_zrun_adv = 6'd0;
            w_advance  = 1'b1;
          end
        end else if (w_coef == '0) begin
          w_zrun_adv = r_zrun + 6'd1;
          w_advance  = 1'b1;
        end else begin
          w_nxt_state = (r_zrun >= 6'd16) ? S_ZRL : S_SYM;
        end
      end
      S_ZRL: begin
        if (w_out_free) begin
          w_load      = 1'b1;
          w_ld_run    = 4'd15;
          w_nxt_zrun  = r_zrun - 6'd16;
          w_nxt_state = (r_zrun >= 6'd32) ? S_ZRL : S_SYM;
        end
      end
      S_SYM: begin
        if (w_out_free) begin
          w_load     = 1'b1;
          w_ld_run   = r_zrun[3:0];
          w_ld_size  = w_sym_size;
          w_ld_amp   = w_sym_amp;
          w_zrun_adv = 6'd0;
          w_advance  = 1'b1;
        end
      end
      S_EOB: begin
        if (w_out_free) begin
          w_load      = 1'b1;
          w_ld_eob    = 1'b1;
          w_nxt_zrun  = 6'd0;
          w_nxt_row   = 3'd0;
          w_nxt_state = S_IDLE;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase

    // Lane 0 closes the row; only row 7 can owe an EOB for trailing zeros.
    if (w_advance) begin
      w_nxt_zrun = w_zrun_adv;
      if (r_lane == 3'd0) begin
        if (r_row == 3'd7) begin
          if (w_zrun_adv != 6'd0) begin
            w_nxt_state = S_EOB;
          end else begin
            w_nxt_state = S_IDLE;
            w_nxt_row   = 3'd0;
          end
        end else begin
          w_nxt_row   = r_row + 3'd1;
          w_nxt_state = S_IDLE;
        end
      end else begin
        w_nxt_lane  = r_lane - 3'd1;
        w_nxt_state = S_SCAN;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_Reset) begin
    if (!i_Reset) begin
      r_state <= S_IDLE;
      r_row   <= 3'd0;
      r_lane  <= 3'd7;
      r_zrun  <= 6'd0;
      r_buf   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_row   <= w_nxt_row;
      r_lane  <= w_nxt_lane;
      r_zrun  <= w_nxt_zrun;
      if (w_accept) r_buf <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_Reset) begin
    if (!i_Reset) begin
      r_valid <= 1'b0;
      r_run   <= 4'd0;
      r_size  <= 4'd0;
      r_amp   <= '0;
      r_dc    <= 1'b0;
      r_eob   <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_run   <= w_ld_run;
      r_size  <= w_ld_size;
      r_amp   <= w_ld_amp;
      r_dc    <= w_ld_dc;
      r_eob   <= w_ld_eob;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_ready = (r_state == S_IDLE);
  assign o_valid = r_valid;
  assign o_run   = r_run;
  assign o_size  = r_size;
  assign o_amp   = r_amp;
  assign o_dc    = r_dc;
  assign o_eob   = r_eob;

endmodule

// File: tb/tb_zz_rle_encoder.sv
// Scoreboard bench for zz_rle_encoder: directed blocks push hand-computed symbols, a monitor pops on handshake.
module tb_zz_rle_encoder;
  localparam int BW = 8;
`ifdef RLE_DC_DIFF_EN
  localparam bit DIFF = 1'b1;
`else
  localparam bit DIFF = 1'b0;
`endif

  logic            i_clk = 1'b0;
  logic            i_Reset;
  logic [8*BW-1:0] i_data;
  logic            i_valid;
  logic            o_ready;
  logic            o_valid;
  logic            i_ready;
  logic [3:0]      o_run;
  logic [3:0]      o_size;
  logic [BW:0]     o_amp;
  logic            o_dc;
  logic            o_eob;

  always #5 i_clk = ~i_clk;

  zz_rle_encoder #(.BW(BW)) dut (
    .i_clk(i_clk), .i_Reset(i_Reset), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_valid(o_valid), .i_ready(i_ready),
    .o_run(o_run), .o_size(o_size), .o_amp(o_amp), .o_dc(o_dc), .o_eob(o_eob)
  );

  typedef struct packed {
    logic [3:0]  run;
    logic [3:0]  size;
    logic [BW:0] amp;
    logic        dc;
    logic        eob;
  } sym_t;

  sym_t exp_q[$];
  sym_t mon_a;
  sym_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   sym_idx = 0;
  int   blk[64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input int run, input int size, input int amp, input bit dc, input bit eob);
    sym_t s;
    s.run  = 4'(run);
    s.size = 4'(size);
    s.amp  = (BW+1)'(amp);
    s.dc   = dc;
    s.eob  = eob;
    exp_q.push_back(s);
  endtask

  task automatic push_dc(input int size_raw, input int amp_raw, input int size_diff, input int amp_diff);
    if (DIFF) push(0, size_diff, amp_diff, 1'b1, 1'b0);
    else      push(0, size_raw, amp_raw, 1'b1, 1'b0);
  endtask

  task automatic clear_blk();
    for (int i = 0; i < 64; i++) blk[i] = 0;
  endtask

  task automatic send_row(input int r);
    logic [8*BW-1:0] d;
    bit ok;
    d = '0;
    for (int k = 0; k < 8; k++) d[k*BW +: BW] = BW'(blk[r*8 + 7 - k]);
    i_data  = d;
    i_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge i_clk);
      if (o_ready) begin
        @(posedge i_clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    i_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL row_accept_timeout row=%0d actual=no_accept required=accept", r);
    end
  endtask

  task automatic send_block(input bit hold);
    for (int r = 0; r < 8; r++) begin
      send_row(r);
      if (r == 0 && hold) begin
        i_ready = 1'b0;
        @(posedge i_clk);
        for (int c = 0; c < 5; c++) begin
          @(negedge i_clk);
          mon_e = (exp_q.size() > 0) ? exp_q[0] : '0;
          chk("hold_valid", 64'(o_valid), 64'd1);
          chk("hold_o_ready", 64'(o_ready), 64'd0);
          chk("hold_fields", 64'({o_run, o_size, o_amp, o_dc, o_eob}), 64'(mon_e));
        end
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
      end
    end
  endtask

  always @(negedge i_clk) begin
    if (i_Reset && o_valid && i_ready) begin
      mon_a = {o_run, o_size, o_amp, o_dc, o_eob};
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_symbol idx=%0d actual=%0h required=none", sym_idx, mon_a);
      end else begin
        mon_e = exp_q.pop_front();
        chk($sformatf("symbol_%0d", sym_idx), 64'(mon_a), 64'(mon_e));
      end
      sym_idx++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    i_Reset = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_data  = '0;
    #12;
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_o_ready", 64'(o_ready), 64'd1);
    chk("rst_fields", 64'({o_run, o_size, o_amp, o_dc, o_eob}), 64'd0);
    i_Reset = 1'b1;
    @(posedge i_clk);
    #1;

    // DC=5, coef1=-3
    clear_blk();
    blk[0] = 5; blk[1] = -3;
    push_dc(3, 5, 3, 5);
    push(0, 2, 0, 0, 0);
    push(0, 0, 0, 0, 1);
    send_block(1'b0);

    // zeros then coef63=1: three ZRLs, no EOB
    clear_blk();
    blk[63] = 1;
    push_dc(0, 0, 3, 2);
    for (int i = 0; i < 3; i++) push(15, 0, 0, 0, 0);
    push(14, 1, 1, 0, 0);
    send_block(1'b0);

    // all -1
    for (int i = 0; i < 64; i++) blk[i] = -1;
    push_dc(1, 0, 1, 0);
    for (int i = 0; i < 63; i++) push(0, 1, 0, 0, 0);
    send_block(1'b0);

    // downstream stall while symbols pending
    clear_blk();
    blk[0] = 5; blk[1] = -3;
    push_dc(3, 5, 3, 6);
    push(0, 2, 0, 0, 0);
    push(0, 0, 0, 0, 1);
    send_block(1'b1);

    // reset during row 4 with a ZRL held at the output
    clear_blk();
    blk[0] = 3; blk[32] = 9;
    push_dc(2, 3, 2, 1);
    for (int r = 0; r < 5; r++) send_row(r);
    i_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("abort_held_valid", 64'(o_valid), 64'd1);
    chk("abort_q_drained", 64'(exp_q.size()), 64'd0);
    i_Reset = 1'b0;
    #1;
    chk("abort_o_valid", 64'(o_valid), 64'd0);
    chk("abort_o_ready", 64'(o_ready), 64'd1);
    chk("abort_fields", 64'({o_run, o_size, o_amp, o_dc, o_eob}), 64'd0);
    @(posedge i_clk);
    #2;
    i_ready = 1'b1;
    i_Reset = 1'b1;
    @(posedge i_clk);
    #1;

    // DC 10 then DC 7 after reset
    clear_blk();
    blk[0] = 10;
    push_dc(4, 10, 4, 10);
    push(0, 0, 0, 0, 1);
    send_block(1'b0);
    clear_blk();
    blk[0] = 7;
    push_dc(3, 7, 2, 0);
    push(0, 0, 0, 0, 1);
    send_block(1'b0);

    // extremes: DC=-128, AC +127, run of 18 before -128
    clear_blk();
    blk[0] = -128; blk[1] = 127; blk[20] = -128;
    push_dc(8, 8'h7F, 8, 8'h78);
    push(0, 7, 127, 0, 0);
    push(15, 0, 0, 0, 0);
    push(2, 8, 8'h7F, 0, 0);
    push(0, 0, 0, 0, 1);
    send_block(1'b0);

    for (int c = 0; c < 3000; c++) begin
      if (exp_q.size() == 0) break;
      @(negedge i_clk);
    end
    chk("final_q_empty", 64'(exp_q.size()), 64'd0);
    repeat (5) @(negedge i_clk);
    chk("final_idle_valid", 64'(o_valid), 64'd0);
    chk("final_idle_ready", 64'(o_ready), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
